// File: rtl/add_unit.sv
// Unsigned WIDTH-bit adder with a combinational sum and a valid-qualified shift pipeline.
// Optional accumulator on the registered path is built when ADD_UNIT_ACCUM_EN is defined.
module add_unit #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
`ifdef ADD_UNIT_ACCUM_EN
    input  logic             acc_clr,
    output logic [WIDTH+7:0] acc,
`endif
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   sum_q,
    output logic             out_valid,
    output logic             ovf_s
);

    logic [PIPE_STAGES-1:0][WIDTH:0] sum_pipe_d, sum_pipe_q;
    logic [PIPE_STAGES-1:0]          valid_d, valid_q;
    logic [PIPE_STAGES-1:0]          ovf_d, ovf_q;
    logic                            ovf_c;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        // Signed overflow: like-signed operands yielding a result of the other sign.
        ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

    always_comb begin
        sum_pipe_d    = sum_pipe_q;
        valid_d       = valid_q;
        ovf_d         = ovf_q;
        sum_pipe_d[0] = sum;
        valid_d[0]    = in_valid;
        ovf_d[0]      = ovf_c;
        for (int i = 1; i < int'(PIPE_STAGES); i++) begin
            sum_pipe_d[i] = sum_pipe_q[i-1];
            valid_d[i]    = valid_q[i-1];
            ovf_d[i]      = ovf_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_pipe_q <= '0;
            valid_q    <= '0;
            ovf_q      <= '0;
        end else begin
            sum_pipe_q <= sum_pipe_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign sum_q     = sum_pipe_q[PIPE_STAGES-1];
    assign out_valid = valid_q[PIPE_STAGES-1];
    assign ovf_s     = ovf_q[PIPE_STAGES-1];

`ifdef ADD_UNIT_ACCUM_EN
    logic [WIDTH+7:0] acc_d, acc_q;

    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (out_valid) begin
            acc_d = acc_q + {7'b0, sum_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
`endif

endmodule

// File: tb/tb_add_unit.sv
// Directed bench for add_unit: a single-stage and a three-stage instance share the operands.
module tb_add_unit;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_valid = 1'b0;
    logic [W:0]   sum1, sumq1, sum3, sumq3;
    logic         ov1, ovf1, ov3, ovf3;
`ifdef ADD_UNIT_ACCUM_EN
    logic         acc_clr = 1'b0;
    logic [W+7:0] acc1, acc3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add_unit #(.WIDTH(W), .PIPE_STAGES(1)) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
`ifdef ADD_UNIT_ACCUM_EN
        .acc_clr  (acc_clr),
        .acc      (acc1),
`endif
        .sum      (sum1),
        .sum_q    (sumq1),
        .out_valid(ov1),
        .ovf_s    (ovf1)
    );

    add_unit #(.WIDTH(W), .PIPE_STAGES(3)) u3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
`ifdef ADD_UNIT_ACCUM_EN
        .acc_clr  (acc_clr),
        .acc      (acc3),
`endif
        .sum      (sum3),
        .sum_q    (sumq3),
        .out_valid(ov3),
        .ovf_s    (ovf3)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         v;
        logic [W:0]   s;
        logic         o;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic v);
        @(negedge clk);
        a        = av;
        b        = bv;
        in_valid = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // a, b, valid, expected sum, expected signed overflow
        tbl[0] = '{4'd4,  4'd4,  1'b1, 5'd8,  1'b1};
        tbl[1] = '{4'd3,  4'd4,  1'b1, 5'd7,  1'b0};
        tbl[2] = '{4'd3,  4'd7,  1'b1, 5'd10, 1'b1};
        tbl[3] = '{4'd15, 4'd15, 1'b1, 5'd30, 1'b0};
        tbl[4] = '{4'd0,  4'd0,  1'b1, 5'd0,  1'b0};
        tbl[5] = '{4'd8,  4'd8,  1'b1, 5'd16, 1'b1};
        tbl[6] = '{4'd2,  4'd3,  1'b0, 5'd5,  1'b0};
        tbl[7] = '{4'd9,  4'd14, 1'b1, 5'd23, 1'b1};
        tbl[8] = '{4'd1,  4'd1,  1'b1, 5'd2,  1'b0};
        tbl[9] = '{4'd6,  4'd9,  1'b1, 5'd15, 1'b0};

        // Reset state; combinational path stays live during reset
        #12;
        check("rst_sumq1", 32'(sumq1), 0);
        check("rst_valid1", 32'(ov1), 0);
        check("rst_ovf1", 32'(ovf1), 0);
        check("rst_sumq3", 32'(sumq3), 0);
        check("rst_valid3", 32'(ov3), 0);
        a = 4'd5;
        b = 4'd6;
        #1;
        check("rst_comb_sum", 32'(sum1), 11);
        @(negedge clk);
        rst_n    = 1'b1;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].v);
            check("comb_sum1", 32'(sum1), 32'(tbl[i].s));
            check("comb_sum3", 32'(sum3), 32'(tbl[i].s));
            tick();
            check("p1_valid", 32'(ov1), 32'(tbl[i].v));
            check("p1_sumq", 32'(sumq1), 32'(tbl[i].s));
            check("p1_ovf", 32'(ovf1), 32'(tbl[i].o));
            if (i >= 2) begin
                check("p3_valid", 32'(ov3), 32'(tbl[i-2].v));
                check("p3_sumq", 32'(sumq3), 32'(tbl[i-2].s));
                check("p3_ovf", 32'(ovf3), 32'(tbl[i-2].o));
            end else begin
                check("p3_fill_valid", 32'(ov3), 0);
            end
        end

        // Three-stage stream 1,0,1 with sums 5, 9, 12
        drive(4'd2, 4'd3, 1'b1);
        tick();
        drive(4'd4, 4'd5, 1'b0);
        tick();
        drive(4'd6, 4'd6, 1'b1);
        tick();
        check("seq_valid0", 32'(ov3), 1);
        check("seq_sum0", 32'(sumq3), 5);
        drive(4'd0, 4'd0, 1'b0);
        tick();
        check("seq_valid1", 32'(ov3), 0);
        drive(4'd0, 4'd0, 1'b0);
        tick();
        check("seq_valid2", 32'(ov3), 1);
        check("seq_sum2", 32'(sumq3), 12);

        // Asynchronous reset with two results in flight
        drive(4'd1, 4'd2, 1'b1);
        tick();
        drive(4'd3, 4'd4, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sumq3", 32'(sumq3), 0);
        check("mid_rst_valid3", 32'(ov3), 0);
        check("mid_rst_ovf3", 32'(ovf3), 0);
        check("mid_rst_valid1", 32'(ov1), 0);
        a = 4'd9;
        b = 4'd9;
        #1;
        check("mid_rst_comb", 32'(sum1), 18);
        @(negedge clk);
        rst_n    = 1'b1;
        a        = 4'd5;
        b        = 4'd6;
        in_valid = 1'b1;
        tick();
        check("post_rst_sumq1", 32'(sumq1), 11);
        check("post_rst_valid1", 32'(ov1), 1);
        check("post_rst_v3_a", 32'(ov3), 0);
        drive(4'd0, 4'd0, 1'b0);
        tick();
        check("post_rst_v3_b", 32'(ov3), 0);
        drive(4'd0, 4'd0, 1'b0);
        tick();
        check("post_rst_v3_c", 32'(ov3), 1);
        check("post_rst_sumq3", 32'(sumq3), 11);

`ifdef ADD_UNIT_ACCUM_EN
        drive(4'd0, 4'd0, 1'b0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("acc_clear0", 32'(acc1), 0);
        drive(4'd4, 4'd4, 1'b1);
        tick();
        drive(4'd3, 4'd4, 1'b1);
        tick();
        check("acc_8", 32'(acc1), 8);
        drive(4'd3, 4'd7, 1'b1);
        tick();
        check("acc_15", 32'(acc1), 15);
        drive(4'd0, 4'd0, 1'b0);
        tick();
        check("acc_25", 32'(acc1), 25);
        drive(4'd0, 4'd0, 1'b0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("acc_clr", 32'(acc1), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
